// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 key schedule.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [0:127] rk_t;
  typedef logic [0:31]  word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_e;

  localparam logic [7:0] RCON [1:AES_NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: field inverse followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  logic [7:0] inv_s;

  assign inv_s = gf_inv(in_i);
  assign out_o = inv_s
               ^ {inv_s[6:0], inv_s[7]}
               ^ {inv_s[5:0], inv_s[7:6]}
               ^ {inv_s[4:0], inv_s[7:5]}
               ^ {inv_s[3:0], inv_s[7:4]}
               ^ 8'h63;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key expansion, one round per clock, with an 11-entry
// round-key file served through a one-cycle-latency request port.
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [0:127] key,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic [0:127] rk,
  output logic         rk_err,
  output logic         busy,
  output logic         done
);

  ks_state_e  state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [3:0] avail_q, avail_d;
  logic       key_ready_q, busy_q, done_q, done_s;
  logic       rk_valid_q, rk_err_q;
  rk_t        rk_q;
  rk_t        rk_file_q [0:AES_NR];

  logic       key_accept_s, load_s, file_we_s, rd_ok_s;
  logic [3:0] prev_idx_s;
  logic [7:0] rc_s;
  rk_t        prev_s, next_rk_s;
  word_t      rot_s, sub_s, t_s, w0_s, w1_s, w2_s, w3_s;

  assign key_accept_s = key_valid && key_ready_q;
  assign rd_ok_s      = rk_req && (rk_idx < avail_q);

  // Round datapath: previous round key and rcon feed one shared SubWord.
  assign prev_idx_s = rnd_q - 4'd1;
  assign prev_s     = (prev_idx_s <= 4'(AES_NR)) ? rk_file_q[prev_idx_s] : '0;
  assign rc_s       = (rnd_q >= 4'd1 && rnd_q <= 4'(AES_NR)) ? RCON[rnd_q] : 8'h00;
  assign rot_s      = {prev_s[104:127], prev_s[96:103]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot_s[8*b +: 8]),
      .out_o (sub_s[8*b +: 8])
    );
  end

  assign t_s       = sub_s ^ {rc_s, 24'h000000};
  assign w0_s      = prev_s[0:31]   ^ t_s;
  assign w1_s      = prev_s[32:63]  ^ w0_s;
  assign w2_s      = prev_s[64:95]  ^ w1_s;
  assign w3_s      = prev_s[96:127] ^ w2_s;
  assign next_rk_s = {w0_s, w1_s, w2_s, w3_s};

  // Next-state logic: key load, round stepping and completion.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    avail_d   = avail_q;
    load_s    = 1'b0;
    file_we_s = 1'b0;
    done_s    = 1'b0;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (key_accept_s) begin
          state_d = ST_EXPAND;
          rnd_d   = 4'd1;
          avail_d = 4'd1;
          load_s  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_EXPAND: begin
        file_we_s = 1'b1;
        avail_d   = rnd_q + 4'd1;
        if (rnd_q == 4'(AES_NR)) begin
          state_d = ST_READY;
          rnd_d   = 4'd0;
          done_s  = 1'b1;
        end else begin
          state_d = ST_EXPAND;
          rnd_d   = rnd_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rnd_d   = 4'd0;
        avail_d = 4'd0;
      end
    endcase
  end

  // Control registers; handshake/status outputs are derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rnd_q       <= 4'd0;
      avail_q     <= 4'd0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      avail_q     <= avail_d;
      key_ready_q <= (state_d != ST_EXPAND);
      busy_q      <= (state_d == ST_EXPAND);
      done_q      <= done_s;
    end
  end

  // Round-key file; contents are not reset because avail gates every read.
  always_ff @(posedge clk) begin
    if (load_s) begin
      rk_file_q[0] <= key;
    end else if (file_we_s) begin
      rk_file_q[rnd_q] <= next_rk_s;
    end else begin
      rk_file_q[0] <= rk_file_q[0];
    end
  end

  // Registered read port; a rejected request leaves rk untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_q       <= '0;
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
    end else begin
      rk_valid_q <= rd_ok_s;
      rk_err_q   <= rk_req && !rd_ok_s;
      if (rd_ok_s) begin
        rk_q <= rk_file_q[rk_idx];
      end else begin
        rk_q <= rk_q;
      end
    end
  end

  assign key_ready = key_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rk_valid  = rk_valid_q;
  assign rk_err    = rk_err_q;
  assign rk        = rk_q;

endmodule
